// File: rtl/beam_trigger_gen.sv
// Per-beam threshold trigger: double-buffered thresholds, registered compare, holdoff FSM.
// Define BEAM_TRIG_SCALER_EN to add per-beam trigger rate scalers with banked readback.
module beam_trigger_gen #(
   parameter int unsigned NBEAMS      = 8,
   parameter int unsigned PWR_BITS    = 18,
   parameter int unsigned HOLDOFF     = 16,
   parameter int unsigned SCAL_BITS   = 16,
   parameter int unsigned SCAL_PERIOD = 1000000
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic [NBEAMS*PWR_BITS-1:0]   power_i,
   input  logic                         power_valid_i,
   input  logic [PWR_BITS-1:0]          thresh_i,
   input  logic [NBEAMS-1:0]            thresh_ce_i,
   input  logic                         update_i,
   input  logic [NBEAMS-1:0]            mask_i,
   output logic [NBEAMS-1:0]            trigger_o,
   output logic                         trig_any_o
`ifdef BEAM_TRIG_SCALER_EN
   ,
   input  logic [(NBEAMS > 1 ? $clog2(NBEAMS) : 1)-1:0] scal_sel_i,
   output logic [SCAL_BITS-1:0]         scal_o,
   output logic                         scal_valid_o
`endif
);

   // HOLDOFF = 0 never enters HOLD; keep a 1-bit counter so widths stay legal.
   localparam int unsigned CntW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

   typedef enum logic [1:0] {StArmed, StFire, StHold} state_e;

   logic [PWR_BITS-1:0] staged_q [NBEAMS];
   logic [PWR_BITS-1:0] active_q [NBEAMS];
   logic [NBEAMS-1:0]   hit_q;
   state_e              state_q  [NBEAMS];
   logic [CntW-1:0]     cnt_q    [NBEAMS];
   logic [NBEAMS-1:0]   trig_q;
   logic                trig_any_q;
   logic [NBEAMS-1:0]   fire;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int b = 0; b < NBEAMS; b++) begin
            staged_q[b] <= '1;
            active_q[b] <= '1;
         end
         hit_q <= '0;
      end else begin
         for (int b = 0; b < NBEAMS; b++) begin
            if (thresh_ce_i[b]) staged_q[b] <= thresh_i;
            // Commit takes the pre-edge staged value, so a same-cycle stage waits.
            if (update_i) active_q[b] <= staged_q[b];
            hit_q[b] <= power_valid_i & ~mask_i[b] &
                        (power_i[b*PWR_BITS +: PWR_BITS] > active_q[b]);
         end
      end
   end

   always_comb begin
      fire = '0;
      for (int b = 0; b < NBEAMS; b++) begin
         fire[b] = (state_q[b] == StArmed) & hit_q[b];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int b = 0; b < NBEAMS; b++) begin
            state_q[b] <= StArmed;
            cnt_q[b]   <= '0;
         end
         trig_q     <= '0;
         trig_any_q <= 1'b0;
      end else begin
         trig_q     <= fire;
         trig_any_q <= |fire;
         for (int b = 0; b < NBEAMS; b++) begin
            unique case (state_q[b])
               StArmed: if (hit_q[b]) state_q[b] <= StFire;
               StFire: begin
                  cnt_q[b]   <= CntW'(HOLDOFF);
                  state_q[b] <= (HOLDOFF > 0) ? StHold : StArmed;
               end
               StHold: begin
                  cnt_q[b] <= cnt_q[b] - CntW'(1);
                  if (cnt_q[b] == CntW'(1)) state_q[b] <= StArmed;
               end
               default: state_q[b] <= StArmed;
            endcase
         end
      end
   end

   assign trigger_o  = trig_q;
   assign trig_any_o = trig_any_q;

`ifdef BEAM_TRIG_SCALER_EN
   localparam int unsigned PerW = $clog2(SCAL_PERIOD);

   logic [PerW-1:0]      per_q;
   logic [SCAL_BITS-1:0] sc_q    [NBEAMS];
   logic [SCAL_BITS-1:0] latch_q [NBEAMS];
   logic [SCAL_BITS-1:0] scal_q;
   logic                 scal_valid_q;
   logic                 term;

   assign term = (per_q == PerW'(SCAL_PERIOD - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         per_q        <= '0;
         scal_q       <= '0;
         scal_valid_q <= 1'b0;
         for (int b = 0; b < NBEAMS; b++) begin
            sc_q[b]    <= '0;
            latch_q[b] <= '0;
         end
      end else begin
         per_q        <= term ? '0 : per_q + PerW'(1);
         scal_valid_q <= term;
         scal_q       <= latch_q[scal_sel_i];
         for (int b = 0; b < NBEAMS; b++) begin
            if (term) begin
               latch_q[b] <= sc_q[b];
               // A trigger in the terminal cycle belongs to the new period.
               sc_q[b]    <= {{(SCAL_BITS-1){1'b0}}, trig_q[b]};
            end else if (trig_q[b] && (sc_q[b] != '1)) begin
               sc_q[b] <= sc_q[b] + SCAL_BITS'(1);
            end
         end
      end
   end

   assign scal_o       = scal_q;
   assign scal_valid_o = scal_valid_q;
`endif

endmodule

// File: tb/tb_beam_trigger_gen.sv
// Self-checking bench for beam_trigger_gen: timestamp-based holdoff model, vector table,
// directed corner sequences and randomized traffic with mid-run resets.
module tb_beam_trigger_gen;

   localparam int NB = 8;
   localparam int PW = 18;
`ifdef BEAM_TRIG_SCALER_EN
   localparam int HOLD = 4;
   localparam int SP   = 100;
   localparam int SB   = 16;
`else
   localparam int HOLD = 16;
`endif

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic [NB*PW-1:0] power  = '0;
   logic             valid  = 1'b0;
   logic [PW-1:0]    thresh = '0;
   logic [NB-1:0]    ce     = '0;
   logic             update = 1'b0;
   logic [NB-1:0]    mask   = '0;
   logic [NB-1:0]    trig;
   logic             any;
`ifdef BEAM_TRIG_SCALER_EN
   logic [2:0]       sel = 3'd0;
   logic [SB-1:0]    scal;
   logic             scal_v;
`endif

   always #5 clk = ~clk;

   beam_trigger_gen #(
      .NBEAMS(NB),
      .PWR_BITS(PW),
      .HOLDOFF(HOLD)
`ifdef BEAM_TRIG_SCALER_EN
      ,
      .SCAL_BITS(SB),
      .SCAL_PERIOD(SP)
`endif
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .power_i(power),
      .power_valid_i(valid),
      .thresh_i(thresh),
      .thresh_ce_i(ce),
      .update_i(update),
      .mask_i(mask),
      .trigger_o(trig),
      .trig_any_o(any)
`ifdef BEAM_TRIG_SCALER_EN
      ,
      .scal_sel_i(sel),
      .scal_o(scal),
      .scal_valid_o(scal_v)
`endif
   );

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string name, input longint act, input longint exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a beam fires at edge e if a hit was registered at e-1 and
   // e is at least HOLD+2 edges after its previous firing.
   logic [PW-1:0] m_act [NB];
   logic [PW-1:0] m_stg [NB];
   bit            m_hit [NB];
   longint        m_ok  [NB];
   longint        ecount = 0;
   logic [NB-1:0] exp_trig = '0;

   int     log_beam = 0;
   longint pulses[$];
   int     anycnt = 0;

   task automatic model_reset();
      for (int b = 0; b < NB; b++) begin
         m_act[b] = '1;
         m_stg[b] = '1;
         m_hit[b] = 1'b0;
         m_ok[b]  = 0;
      end
      exp_trig = '0;
   endtask

   task automatic model_edge();
      logic [PW-1:0] pw;
      ecount++;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int b = 0; b < NB; b++) begin
         exp_trig[b] = m_hit[b] && (ecount >= m_ok[b]);
         if (exp_trig[b]) m_ok[b] = ecount + HOLD + 2;
      end
      for (int b = 0; b < NB; b++) begin
         pw = power[b*PW +: PW];
         m_hit[b] = valid && !mask[b] && (pw > m_act[b]);
      end
      for (int b = 0; b < NB; b++) begin
         if (update) m_act[b] = m_stg[b];
         if (ce[b]) m_stg[b] = thresh;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("trigger_o", trig, exp_trig);
      check("trig_any_o", any, |exp_trig);
      if (trig[log_beam]) pulses.push_back(ecount);
      if (any) anycnt++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic set_pw(input int b, input int unsigned v);
      power[b*PW +: PW] = PW'(v);
   endtask

   task automatic quiet();
      valid  = 1'b0;
      ce     = '0;
      update = 1'b0;
      power  = '0;
   endtask

   task automatic stage_commit(input int b, input int unsigned v);
      thresh = PW'(v);
      ce     = NB'(1) << b;
      step();
      ce     = '0;
      update = 1'b1;
      step();
      update = 1'b0;
   endtask

   typedef struct {
      int            rep;
      logic [PW-1:0] p0;
      logic          vld;
      logic [PW-1:0] th;
      logic          ce0;
      logic          upd;
      logic [NB-1:0] exp;
   } vec_t;

   vec_t tbl[11];

`ifdef BEAM_TRIG_SCALER_EN
   task automatic wait_scal_valid(input string name);
      int n = 0;
      while (!scal_v && n < 150) begin
         step();
         n++;
      end
      check(name, scal_v, 1);
   endtask
`endif

   initial begin
      longint n0;
      model_reset();
      run(3);
      rst_n = 1'b1;
      check("reset trigger_o", trig, 0);
      check("reset trig_any_o", any, 0);

`ifdef BEAM_TRIG_SCALER_EN
      // Scaler: sync to a bank boundary, fire beam 1 seven times within one period.
      sel = 3'd1;
      wait_scal_valid("scal sync");
      step();
      check("scal empty bank", scal, 0);
      stage_commit(1, 500);
      log_beam = 1;
      pulses.delete();
      set_pw(1, 501);
      valid = 1'b1;
      for (int i = 0; i < 200 && pulses.size() < 7; i++) step();
      quiet();
      check("scal pulses", pulses.size(), 7);
      wait_scal_valid("scal period");
      step();
      check("scal count", scal, 7);
      check("scal_valid width", scal_v, 0);
      // Reset mid-period clears everything and restarts counting.
      set_pw(1, 501);
      valid = 1'b1;
      run(10);
      quiet();
      rst_n = 1'b0;
      #1;
      check("scal reset", scal, 0);
      check("scal_valid reset", scal_v, 0);
      run(2);
      rst_n = 1'b1;
      wait_scal_valid("scal after reset");
      step();
      check("scal restart", scal, 0);
`endif

      // All-ones thresholds can never be exceeded.
      anycnt = 0;
      for (int b = 0; b < NB; b++) set_pw(b, 32'h3FFFF);
      valid = 1'b1;
      run(100);
      quiet();
      check("all-ones no trigger", anycnt, 0);

      // Staged but uncommitted threshold has no effect.
      thresh = PW'(9000);
      ce     = 8'h04;
      step();
      ce     = '0;
      log_beam = 2;
      pulses.delete();
      set_pw(2, 9001);
      valid = 1'b1;
      run(5);
      valid = 1'b0;
      check("uncommitted no trigger", pulses.size(), 0);
      update = 1'b1;
      step();
      update = 1'b0;
      run(2);
      pulses.delete();
      valid = 1'b1;
      step();
      n0 = ecount;
      valid = 1'b0;
      run(10);
      check("single pulse count", pulses.size(), 1);
      if (pulses.size() >= 1) check("single pulse latency", pulses[0] - n0, 1);

      // Equal never hits; continuous above-threshold repeats every HOLD+2.
      run(20);
      set_pw(2, 9000);
      valid = 1'b1;
      pulses.delete();
      run(40);
      check("equal no trigger", pulses.size(), 0);
      set_pw(2, 9001);
      step();
      n0 = ecount;
      run(40);
      quiet();
      check("repeat count", pulses.size() >= 3, 1);
      if (pulses.size() >= 3) begin
         check("repeat 1st", pulses[0] - n0, 1);
         check("repeat 2nd", pulses[1] - n0, HOLD + 3);
         check("repeat 3rd", pulses[2] - n0, 2 * HOLD + 5);
      end
      run(HOLD + 4);

      // Stage/commit ordering on beam 0.
      tbl[0]  = '{1,  18'd0,   1'b0, 18'd500, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1,  18'd0,   1'b0, 18'd0,   1'b0, 1'b1, 8'h00};
      tbl[2]  = '{1,  18'd0,   1'b0, 18'd300, 1'b1, 1'b1, 8'h00};
      tbl[3]  = '{1,  18'd499, 1'b1, 18'd0,   1'b0, 1'b0, 8'h00};
      tbl[4]  = '{1,  18'd501, 1'b1, 18'd0,   1'b0, 1'b0, 8'h00};
      tbl[5]  = '{1,  18'd0,   1'b0, 18'd0,   1'b0, 1'b0, 8'h01};
      tbl[6]  = '{1,  18'd0,   1'b0, 18'd0,   1'b0, 1'b1, 8'h00};
      tbl[7]  = '{20, 18'd0,   1'b0, 18'd0,   1'b0, 1'b0, 8'h00};
      tbl[8]  = '{1,  18'd300, 1'b1, 18'd0,   1'b0, 1'b0, 8'h00};
      tbl[9]  = '{1,  18'd301, 1'b1, 18'd0,   1'b0, 1'b0, 8'h00};
      tbl[10] = '{1,  18'd0,   1'b0, 18'd0,   1'b0, 1'b0, 8'h01};
      for (int i = 0; i < 11; i++) begin
         set_pw(0, 32'(tbl[i].p0));
         valid  = tbl[i].vld;
         thresh = tbl[i].th;
         ce     = {7'b0, tbl[i].ce0};
         update = tbl[i].upd;
         repeat (tbl[i].rep) begin
            step();
            check($sformatf("tbl[%0d]", i), trig, tbl[i].exp);
         end
      end
      quiet();
      run(HOLD + 4);

      // Mask after a registered hit does not abort; mask blocks new hits.
      stage_commit(5, 100);
      log_beam = 5;
      pulses.delete();
      set_pw(5, 200);
      valid = 1'b1;
      step();
      n0 = ecount;
      mask[5] = 1'b1;
      run(40);
      check("masked pulse count", pulses.size(), 1);
      if (pulses.size() >= 1) check("masked pulse latency", pulses[0] - n0, 1);
      mask[5] = 1'b0;
      step();
      n0 = ecount;
      run(5);
      check("unmask pulse count", pulses.size(), 2);
      if (pulses.size() >= 2) check("unmask pulse latency", pulses[1] - n0, 1);

      // Reset mid-HOLD: immediate ARMED, no pulse during reset.
      pulses.delete();
      run(HOLD / 2);
      quiet();
      rst_n = 1'b0;
      #1;
      check("async reset trigger_o", trig, 0);
      run(2);
      rst_n = 1'b1;
      stage_commit(5, 100);
      pulses.delete();
      set_pw(5, 200);
      valid = 1'b1;
      step();
      n0 = ecount;
      valid = 1'b0;
      run(3);
      check("post-reset pulse count", pulses.size(), 1);
      if (pulses.size() >= 1) check("post-reset latency", pulses[0] - n0, 1);
      quiet();

      // Random traffic against the model, with periodic async resets.
      for (int c = 0; c < 1600; c++) begin
         valid = ($urandom_range(0, 3) != 0);
         for (int b = 0; b < NB; b++) set_pw(b, $urandom_range(0, 1200));
         mask   = NB'($urandom & $urandom & $urandom);
         ce     = ($urandom_range(0, 5) == 0) ? NB'($urandom) : '0;
         thresh = ($urandom_range(0, 9) == 0) ? '1 : PW'($urandom_range(200, 1000));
         update = ($urandom_range(0, 7) == 0);
         if (c % 400 == 399) begin
            rst_n = 1'b0;
            #1;
            check("rand async reset", {any, trig}, 0);
            run(2);
            rst_n = 1'b1;
         end else begin
            step();
         end
      end
      quiet();
      run(3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
